hazard_unit: RTL and testbench

//  Pipeline hazard responder for the 5-stage ARM core. It consumes the controller's

---
 rtl/hazard_unit_if.sv | 39 +++
 rtl/hazard_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: hazard inputs from the controller and stall/flush/forward controls back.
// The master side is the controller/datapath; the slave side is hazard_unit.
interface hazard_unit_if #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] RA1D;
   logic [REG_AW-1:0] RA2D;
   logic [REG_AW-1:0] WA3D;
   logic              RegWriteM;
   logic              RegWriteW;
   logic              MemtoRegE;
   logic              PCWrPendingF;
   logic              BranchTakenE;
   logic              PCSrcW;
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
   logic              HazardErr;
   logic [CNT_W-1:0]  StallCount;
   logic [CNT_W-1:0]  FlushCount;

   modport master (
      output RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
             PCWrPendingF, BranchTakenE, PCSrcW,
      input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
             HazardErr, StallCount, FlushCount
   );

   modport slave (
      input  RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
             PCWrPendingF, BranchTakenE, PCSrcW,
      output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
             HazardErr, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard responder for the 5-stage ARM core: forwarding, load-use stall, flushes, stall watchdog.
// Optional feature macro: HAZARD_PERF_EN adds saturating StallCount/FlushCount performance counters.
module hazard_unit #(
   parameter int REG_AW    = 4,
   parameter int MAX_STALL = 8,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave bus
);
   localparam int                RUN_W   = $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL);
   localparam logic [REG_AW-1:0] PC_REG  = REG_AW'(15);

   logic [REG_AW-1:0] r_ra1e;
   logic [REG_AW-1:0] r_ra2e;
   logic [REG_AW-1:0] r_wa3e;
   logic              r_ve;
   logic [REG_AW-1:0] r_wa3m;
   logic [REG_AW-1:0] r_wa3w;
   logic [RUN_W-1:0]  r_run_cnt;
   logic              r_hazard_err;

   logic              w_ldr_stall;
   logic              w_stall_f;
   logic              w_stall_d;
   logic              w_flush_d;
   logic              w_flush_e;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   // M stage wins over W; R15 reads come from the PC path, never from a forward.
   function automatic logic [1:0] fwd_sel(
      input logic              v,
      input logic [REG_AW-1:0] ra,
      input logic [REG_AW-1:0] wa_m,
      input logic [REG_AW-1:0] wa_w,
      input logic              we_m,
      input logic              we_w
   );
      logic [1:0] sel;
      if (!v || (ra == PC_REG)) begin
         sel = 2'b00;
      end else if (we_m && (ra == wa_m)) begin
         sel = 2'b10;
      end else if (we_w && (ra == wa_w)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   always_comb begin
      w_ldr_stall = bus.MemtoRegE & ((bus.RA1D == r_wa3e) | (bus.RA2D == r_wa3e));
      w_stall_d   = w_ldr_stall;
      w_stall_f   = w_ldr_stall | bus.PCWrPendingF;
      w_flush_d   = bus.PCWrPendingF | bus.PCSrcW | bus.BranchTakenE;
      w_flush_e   = w_ldr_stall | bus.BranchTakenE;
      w_fwd_a     = fwd_sel(r_ve, r_ra1e, r_wa3m, r_wa3w, bus.RegWriteM, bus.RegWriteW);
      w_fwd_b     = fwd_sel(r_ve, r_ra2e, r_wa3m, r_wa3w, bus.RegWriteM, bus.RegWriteW);
   end

   assign bus.StallF    = w_stall_f;
   assign bus.StallD    = w_stall_d;
   assign bus.FlushD    = w_flush_d;
   assign bus.FlushE    = w_flush_e;
   assign bus.ForwardAE = w_fwd_a;
   assign bus.ForwardBE = w_fwd_b;
   assign bus.HazardErr = r_hazard_err;

   // M/W destination tags are never flushed; the write enables qualify them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ra1e <= {REG_AW{1'b0}};
         r_ra2e <= {REG_AW{1'b0}};
         r_wa3e <= {REG_AW{1'b0}};
         r_ve   <= 1'b0;
         r_wa3m <= {REG_AW{1'b0}};
         r_wa3w <= {REG_AW{1'b0}};
      end else begin
         if (w_flush_e) begin
            r_ra1e <= {REG_AW{1'b0}};
            r_ra2e <= {REG_AW{1'b0}};
            r_wa3e <= {REG_AW{1'b0}};
            r_ve   <= 1'b0;
         end else begin
            r_ra1e <= bus.RA1D;
            r_ra2e <= bus.RA2D;
            r_wa3e <= bus.WA3D;
            r_ve   <= 1'b1;
         end
         r_wa3m <= r_wa3e;
         r_wa3w <= r_wa3m;
      end
   end

   // Error latches on the edge the run counter reaches MAX_STALL and is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run_cnt    <= {RUN_W{1'b0}};
         r_hazard_err <= 1'b0;
      end else if (w_stall_f) begin
         if (r_run_cnt != RUN_MAX) begin
            r_run_cnt <= r_run_cnt + RUN_W'(1);
         end else begin
            r_run_cnt <= r_run_cnt;
         end
         if (r_run_cnt == (RUN_MAX - RUN_W'(1))) begin
            r_hazard_err <= 1'b1;
         end else begin
            r_hazard_err <= r_hazard_err;
         end
      end else begin
         r_run_cnt    <= {RUN_W{1'b0}};
         r_hazard_err <= r_hazard_err;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= {CNT_W{1'b0}};
         r_flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
         if (w_flush_e && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end else begin
            r_flush_cnt <= r_flush_cnt;
         end
      end
   end

   assign bus.StallCount = r_stall_cnt;
   assign bus.FlushCount = r_flush_cnt;
`else
   assign bus.StallCount = {CNT_W{1'b0}};
   assign bus.FlushCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: reference model feeds an expected-value queue,
// plus directed checks for the forwarding, load-use, branch, PC-write and watchdog scenarios.
module tb_hazard_unit;
   localparam int AW = 4;
   localparam int MS = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

   hazard_unit #(.REG_AW(AW), .MAX_STALL(MS), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic          sf;
      logic          sd;
      logic          fd;
      logic          fe;
      logic          err;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   errors = 0;
   int   checks = 0;

   logic [AW-1:0] m_ra1e, m_ra2e, m_wa3e, m_wa3m, m_wa3w;
   logic          m_ve, m_err;
   int            m_run;
   logic [CW-1:0] m_scnt, m_fcnt;

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] ra, input logic wm, input logic ww);
      if (!m_ve || ra == 4'd15) return 2'b00;
      if (wm && ra == m_wa3m)   return 2'b10;
      if (ww && ra == m_wa3w)   return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ra1e = 4'd0; m_ra2e = 4'd0; m_wa3e = 4'd0; m_wa3m = 4'd0; m_wa3w = 4'd0;
      m_ve = 1'b0; m_err = 1'b0; m_run = 0; m_scnt = '0; m_fcnt = '0;
   endtask

   task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                        input logic rwm, input logic rww, input logic mte,
                        input logic pcw, input logic bte, input logic pcsw);
      bus.RA1D = ra1; bus.RA2D = ra2; bus.WA3D = wa3;
      bus.RegWriteM = rwm; bus.RegWriteW = rww; bus.MemtoRegE = mte;
      bus.PCWrPendingF = pcw; bus.BranchTakenE = bte; bus.PCSrcW = pcsw;
   endtask

   // Build the expectation for the current inputs, queue it, then compare against the DUT.
   task automatic sample();
      exp_t e;
      exp_t g;
      logic ldr;
      #1;
      ldr   = bus.MemtoRegE & ((bus.RA1D == m_wa3e) | (bus.RA2D == m_wa3e));
      e.fa  = m_fwd(m_ra1e, bus.RegWriteM, bus.RegWriteW);
      e.fb  = m_fwd(m_ra2e, bus.RegWriteM, bus.RegWriteW);
      e.sd  = ldr;
      e.sf  = ldr | bus.PCWrPendingF;
      e.fd  = bus.PCWrPendingF | bus.PCSrcW | bus.BranchTakenE;
      e.fe  = ldr | bus.BranchTakenE;
      e.err = m_err;
`ifdef HAZARD_PERF_EN
      e.sc  = m_scnt;
      e.fc  = m_fcnt;
`else
      e.sc  = '0;
      e.fc  = '0;
`endif
      q.push_back(e);
      m_e = e;
      g = q.pop_front();
      chk_val("ForwardAE",  32'(bus.ForwardAE),  32'(g.fa));
      chk_val("ForwardBE",  32'(bus.ForwardBE),  32'(g.fb));
      chk_val("StallF",     32'(bus.StallF),     32'(g.sf));
      chk_val("StallD",     32'(bus.StallD),     32'(g.sd));
      chk_val("FlushD",     32'(bus.FlushD),     32'(g.fd));
      chk_val("FlushE",     32'(bus.FlushE),     32'(g.fe));
      chk_val("HazardErr",  32'(bus.HazardErr),  32'(g.err));
      chk_val("StallCount", 32'(bus.StallCount), 32'(g.sc));
      chk_val("FlushCount", 32'(bus.FlushCount), 32'(g.fc));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         m_wa3w = m_wa3m;
         m_wa3m = m_wa3e;
         if (m_e.fe) begin
            m_ra1e = 4'd0; m_ra2e = 4'd0; m_wa3e = 4'd0; m_ve = 1'b0;
         end else begin
            m_ra1e = bus.RA1D; m_ra2e = bus.RA2D; m_wa3e = bus.WA3D; m_ve = 1'b1;
         end
         if (m_e.sf) begin
            if (m_run == MS - 1) m_err = 1'b1;
            if (m_run < MS) m_run++;
         end else begin
            m_run = 0;
         end
         if (m_e.sf && m_scnt != '1) m_scnt++;
         if (m_e.fe && m_fcnt != '1) m_fcnt++;
      end
      #1;
   endtask

   task automatic cyc();
      sample();
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      sample();
      chk_val("rst_err", 32'(bus.HazardErr), 32'd0);
      tick();
      reset = 1'b0;
   endtask

   task automatic idle();
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Writer of rn two cycles back and one cycle back, then reader of rn in E.
   task automatic fwd_case(input logic [3:0] rn, input logic rwm, input logic rww,
                           input logic [1:0] exp_fa, input string tag);
      drive(4'd0, 4'd0, rn,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      drive(4'd0, 4'd0, rn,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      drive(rn,   4'd0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      drive(4'd0, 4'd0, 4'd0,  rwm,  rww,  1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      chk_val({tag, "_fa"}, 32'(bus.ForwardAE), 32'(exp_fa));
      chk_val({tag, "_fb"}, 32'(bus.ForwardBE), 32'd0);
      tick();
   endtask

   initial begin
      logic [3:0] regs [5];
      regs[0] = 4'd0; regs[1] = 4'd1; regs[2] = 4'd2; regs[3] = 4'd3; regs[4] = 4'd15;
      idle();
      do_reset();

      fwd_case(4'd1,  1'b1, 1'b0, 2'b10, "t1_m");
      fwd_case(4'd1,  1'b0, 1'b1, 2'b01, "t2_w");
      fwd_case(4'd1,  1'b1, 1'b1, 2'b10, "t2_mw");
      fwd_case(4'd15, 1'b1, 1'b1, 2'b00, "r15");

      // Load-use on R2: the flushed E stage must not forward despite WA3M=2.
      drive(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      drive(4'd0, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      chk_val("t3_stallf", 32'(bus.StallF), 32'd1);
      chk_val("t3_stalld", 32'(bus.StallD), 32'd1);
      chk_val("t3_flushe", 32'(bus.FlushE), 32'd1);
      tick();
      drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      chk_val("t3_fb", 32'(bus.ForwardBE), 32'd0);
      tick();

      // Taken branch bubbles the instruction reading R3.
      drive(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      drive(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      sample();
      chk_val("t4_flushd", 32'(bus.FlushD), 32'd1);
      chk_val("t4_flushe", 32'(bus.FlushE), 32'd1);
      chk_val("t4_stallf", 32'(bus.StallF), 32'd0);
      tick();
      drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      chk_val("t4_fa", 32'(bus.ForwardAE), 32'd0);
      tick();

      // PC write pending for three cycles, then retired in W.
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         sample();
         chk_val("t5_stallf", 32'(bus.StallF), 32'd1);
         chk_val("t5_flushd", 32'(bus.FlushD), 32'd1);
         tick();
      end
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      sample();
      chk_val("t5_stallf_end", 32'(bus.StallF), 32'd0);
      chk_val("t5_flushd_end", 32'(bus.FlushD), 32'd1);
      tick();
      idle();
      sample();
      chk_val("t5_err", 32'(bus.HazardErr), 32'd0);
      tick();

      // Constrained-random traffic with frequent register collisions.
      for (int i = 0; i < 300; i++) begin
         drive(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
         cyc();
      end

      // Watchdog: eight stalled edges trip the sticky error.
      idle();
      do_reset();
      for (int i = 0; i < MS; i++) begin
         drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         sample();
         chk_val("t6_err_pre", 32'(bus.HazardErr), 32'd0);
         tick();
      end
      sample();
      chk_val("t6_err", 32'(bus.HazardErr), 32'd1);
`ifdef HAZARD_PERF_EN
      chk_val("t6_scnt", 32'(bus.StallCount), 32'd8);
      chk_val("t6_fcnt", 32'(bus.FlushCount), 32'd0);
`endif
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk_val("t6_err_hold", 32'(bus.HazardErr), 32'd1);
         tick();
      end

      // Reset asserted while stalled clears the error immediately.
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      do_reset();
      idle();
      for (int i = 0; i < 3; i++) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
